ram8_arbiter: RTL and testbench

Sequencer and two-port arbiter for one Hack RAM8 bank: eight 16-bit registers with a one-hot load fan-out and a shared read mux. Port A is the CPU data port; port B is the MiSTer loader/host port. The block grants the bank to one requester at a time in round-robin order and drives the bank address, write data and per-register load. It runs a fixed three-state access cycle and returns read data with a single-cycle acknowledge.

---
 rtl/ram8_arbiter.sv | 152 +++++++++++++++
 tb/tb_ram8_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ram8_arbiter.sv
// Round-robin two-port sequencer for one RAM8 bank: IDLE/ACCESS/DONE, ack 2 cycles after grant, 1 txn per 3 cycles.
// Requesters hold req until ack; RAM8_ARB_LOCK_EN lets the finishing port keep the bank via its lock.
module ram8_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [2:0]       a_addr,
  input  logic [WIDTH-1:0] a_wdata,
  input  logic             a_lock,
  output logic             a_ack,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [2:0]       b_addr,
  input  logic [WIDTH-1:0] b_wdata,
  input  logic             b_lock,
  output logic             b_ack,
  output logic [WIDTH-1:0] rdata,
  output logic [2:0]       bank_addr,
  output logic [WIDTH-1:0] bank_in,
  output logic [7:0]       bank_load,
  input  logic [WIDTH-1:0] bank_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic             cmd_we_q, cmd_we_d;
  logic [2:0]       cmd_addr_q, cmd_addr_d;
  logic [WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             a_ack_q, a_ack_d;
  logic             b_ack_q, b_ack_d;
  logic             hold_q, hold_d;

  logic             any_req;
  logic             winner;
  logic             win_we;
  logic [2:0]       win_addr;
  logic [WIDTH-1:0] win_wdata;

  always_comb begin
    any_req = a_req | b_req;
    if (a_req && b_req) begin
      winner = ~last_q;
    end else begin
      winner = b_req ? PORT_B : PORT_A;
    end
`ifdef RAM8_ARB_LOCK_EN
    // A locked owner that re-requests right after its ack bypasses round-robin.
    if (hold_q && ((owner_q == PORT_B) ? b_req : a_req)) begin
      winner = owner_q;
    end
`endif
    win_we    = (winner == PORT_B) ? b_we    : a_we;
    win_addr  = (winner == PORT_B) ? b_addr  : a_addr;
    win_wdata = (winner == PORT_B) ? b_wdata : a_wdata;
  end

`ifndef RAM8_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = a_lock | b_lock;
`endif

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rdata_d     = rdata_q;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    hold_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          owner_d     = winner;
          last_d      = winner;
          cmd_we_d    = win_we;
          cmd_addr_d  = win_addr;
          cmd_wdata_d = win_wdata;
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        rdata_d = cmd_we_q ? cmd_wdata_q : bank_out;
        a_ack_d = (owner_q == PORT_A);
        b_ack_d = (owner_q == PORT_B);
        state_d = S_DONE;
      end
      S_DONE: begin
`ifdef RAM8_ARB_LOCK_EN
        hold_d = (owner_q == PORT_B) ? b_lock : a_lock;
`endif
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      last_q      <= PORT_B;
      owner_q     <= PORT_A;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= 3'd0;
      cmd_wdata_q <= '0;
      rdata_q     <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      hold_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rdata_q     <= rdata_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      hold_q      <= hold_d;
    end
  end

  // Reset gates the load combinationally so a write caught in ACCESS never commits.
  assign bank_load = (state_q == S_ACCESS && cmd_we_q && !reset) ? (8'h01 << cmd_addr_q) : 8'h00;
  assign bank_addr = cmd_addr_q;
  assign bank_in   = cmd_wdata_q;
  assign rdata     = rdata_q;
  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign busy      = (state_q == S_ACCESS) || (state_q == S_DONE);

endmodule

// File: tb/tb_ram8_arbiter.sv
// Directed bench for ram8_arbiter with an external RAM8 bank model.
module tb_ram8_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [2:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_ack, b_ack, busy;
  logic [15:0] rdata, bank_in, bank_out;
  logic [2:0]  bank_addr;
  logic [7:0]  bank_load;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram8_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock), .b_ack(b_ack),
    .rdata(rdata), .bank_addr(bank_addr), .bank_in(bank_in), .bank_load(bank_load),
    .bank_out(bank_out), .busy(busy)
  );

  // Bank model: eight registers, one-hot load, combinational read mux.
  logic [15:0] mem [8];
  logic        mem_clr;
  assign bank_out = mem[bank_addr];
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (mem_clr) mem[i] <= 16'h0;
      else if (bank_load[i]) mem[i] <= bank_in;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bank_load !== 8'h00) begin
      check("load_onehot", {31'd0, $onehot(bank_load)}, 1);
      check("load_busy", {31'd0, busy}, 1);
    end
  end

  task automatic drive(input logic port, input logic req, input logic we,
                       input logic [2:0] addr, input logic [15:0] wdata);
    if (port) begin
      b_req = req; b_we = we; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
    end
  endtask

  task automatic run_txn(input logic port, input logic we, input logic [2:0] addr,
                         input logic [15:0] wdata, input bit chg,
                         output int lat, output logic [15:0] rd,
                         output logic [7:0] load_or, output int load_cyc);
    bit got;
    got = 0; lat = 0; rd = '0; load_or = '0; load_cyc = 0;
    @(negedge clk);
    drive(port, 1'b1, we, addr, wdata);
    while (!got && lat < 12) begin
      @(negedge clk);
      lat++;
      if (bank_load !== 8'h00) begin
        load_or = load_or | bank_load;
        load_cyc++;
      end
      if (lat == 1) begin
        check("bank_addr", {29'd0, bank_addr}, {29'd0, addr});
        if (chg) drive(port, 1'b1, we, 3'd6, 16'hFFFF);
      end
      if ((port ? b_ack : a_ack) === 1'b1) begin
        got = 1;
        rd  = rdata;
        check("other_ack", {31'd0, (port ? a_ack : b_ack)}, 0);
      end
    end
    drive(port, 1'b0, 1'b0, 3'd0, 16'h0);
    check("ack_seen", {31'd0, got}, 1);
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int          lat, load_cyc, cyc, n, a_cnt;
    logic [15:0] rd;
    logic [7:0]  load_or;
    logic        p [4];
    int          t [4];
    logic        exp_seq [4];

    reset = 1'b1; mem_clr = 1'b1;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_lock = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_lock = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0; mem_clr = 1'b0;

    check("rst_load", {24'd0, bank_load}, 0);
    check("rst_addr", {29'd0, bank_addr}, 0);
    check("rst_bank_in", {16'd0, bank_in}, 0);
    check("rst_rdata", {16'd0, rdata}, 0);
    check("rst_acks", {30'd0, a_ack, b_ack}, 0);
    check("rst_busy", {31'd0, busy}, 0);

    vecs.push_back('{1'b0, 1'b1, 3'd5, 16'h1234, 16'h1234});
    vecs.push_back('{1'b0, 1'b0, 3'd5, 16'h0000, 16'h1234});
    for (int i = 0; i < 8; i++) vecs.push_back('{1'b1, 1'b1, 3'(i), 16'(i + 1), 16'(i + 1)});
    for (int i = 0; i < 8; i++) vecs.push_back('{1'b0, 1'b0, 3'(i), 16'h0000, 16'(i + 1)});
    vecs.push_back('{1'b1, 1'b1, 3'd3, 16'hBEEF, 16'hBEEF});
    vecs.push_back('{1'b1, 1'b0, 3'd3, 16'h0000, 16'hBEEF});

    foreach (vecs[i]) begin
      run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0, lat, rd, load_or, load_cyc);
      check("latency", lat, 2);
      check("rdata", {16'd0, rd}, {16'd0, vecs[i].exp});
      check("load_mask", {24'd0, load_or}, {24'd0, (vecs[i].we ? (8'h01 << vecs[i].addr) : 8'h00)});
      check("load_cycles", load_cyc, {31'd0, vecs[i].we});
    end

    // Command changes after grant must be ignored.
    run_txn(1'b0, 1'b1, 3'd3, 16'h0C0C, 1'b1, lat, rd, load_or, load_cyc);
    check("chg_load", {24'd0, load_or}, 32'h08);
    @(negedge clk);
    check("chg_mem3", {16'd0, mem[3]}, 32'h0C0C);
    check("chg_mem6", {16'd0, mem[6]}, 32'h0007);

    // Reset during the ACCESS cycle of a write to addr 2.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 3'd2, 16'h5555);
    @(negedge clk);
    check("rst_mid_busy", {31'd0, busy}, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_load", {24'd0, bank_load}, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    check("rst_mid_outs", {bank_load, 5'd0, bank_addr, 3'd0, a_ack, b_ack, busy, 10'd0}, 0);
    check("rst_mid_bank_in", {16'd0, bank_in}, 0);
    check("rst_mid_rdata", {16'd0, rdata}, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_mid_noack", {30'd0, a_ack, b_ack}, 0);
    end
    check("rst_mid_mem2", {16'd0, mem[2]}, 32'h0003);

    // Contention straight after reset: A first, then strict alternation.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 3'd1, 16'h0);
    cyc = 0; n = 0;
    for (int k = 0; k < 4; k++) begin p[k] = 1'bx; t[k] = -1; end
    while (n < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (a_ack === 1'b1 && b_ack === 1'b1) check("dual_ack", 1, 0);
      if (a_ack === 1'b1) begin p[n] = 1'b0; t[n] = cyc; n++; end
      else if (b_ack === 1'b1) begin p[n] = 1'b1; t[n] = cyc; n++; end
    end
    a_req = 0; b_req = 0;
    check("cont_count", n, 4);
    check("cont_first_lat", t[0], 2);
    check("cont_b_after_a", t[1] - t[0], 3);
    check("cont_seq", {28'd0, p[0], p[1], p[2], p[3]}, 32'b0101);

    // Lock: A locks for three transactions while B requests continuously.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
`ifdef RAM8_ARB_LOCK_EN
    exp_seq[0] = 1'b0; exp_seq[1] = 1'b0; exp_seq[2] = 1'b0; exp_seq[3] = 1'b1;
`else
    exp_seq[0] = 1'b0; exp_seq[1] = 1'b1; exp_seq[2] = 1'b0; exp_seq[3] = 1'b1;
`endif
    drive(1'b0, 1'b1, 1'b0, 3'd4, 16'h0);
    a_lock = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 3'd2, 16'h0);
    cyc = 0; n = 0; a_cnt = 0;
    for (int k = 0; k < 4; k++) p[k] = 1'bx;
    while (n < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (a_ack === 1'b1) begin
        p[n] = 1'b0; n++; a_cnt++;
        if (a_cnt == 3) begin a_req = 0; a_lock = 0; end
      end else if (b_ack === 1'b1) begin
        p[n] = 1'b1; n++;
      end
    end
    a_req = 0; a_lock = 0; b_req = 0;
    check("lock_count", n, 4);
    check("lock_seq", {28'd0, p[0], p[1], p[2], p[3]},
          {28'd0, exp_seq[0], exp_seq[1], exp_seq[2], exp_seq[3]});

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
